// File: rtl/inp_pio_edge_ctrl_if.sv
// Avalon-MM slave bus bundle for the panel input PIO: register select, write strobe and read data.
interface inp_pio_edge_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/inp_pio_edge_ctrl.sv
// Panel input PIO: synchronised inputs, per-channel rise/fall edge capture (W1C), saturating event counter, irq.
// Define INP_PIO_DEBOUNCE_EN to add a per-channel debounce filter between the synchroniser and edge detect.
module inp_pio_edge_ctrl #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 16,
    parameter int DEB_CYCLES  = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    inp_pio_edge_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_EVT_CNT  = 3'd5;

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   sync;
    logic [WIDTH-1:0]   stable;
    logic [WIDTH-1:0]   prev;
    logic [WIDTH-1:0]   rise_en;
    logic [WIDTH-1:0]   fall_en;
    logic [WIDTH-1:0]   irq_mask;
    logic [WIDTH-1:0]   capture;
    logic [COUNT_W-1:0] evt_count;
    logic [WIDTH-1:0]   qual;
    logic               wr_en;
    logic [WIDTH-1:0]   wr_bits;
    logic [31:0]        rd_mux;
    logic               wr_unused;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wr_bits   = bus.writedata[WIDTH-1:0];
    assign wr_unused = ^bus.writedata;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef INP_PIO_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [DEB_W-1:0] deb_cnt [WIDTH];

    // A channel's level is accepted on the cycle its mismatch run reaches DEB_CYCLES.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stable[i]  <= sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    localparam int DEB_UNUSED = DEB_CYCLES;
    assign stable = sync;
`endif

    assign qual = (stable & ~prev & rise_en) | (~stable & prev & fall_en);
    assign irq  = |(capture & irq_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            irq_mask <= '0;
            capture  <= '0;
        end else begin
            prev <= stable;
            if (wr_en && bus.address == ADDR_RISE_EN)  rise_en  <= wr_bits;
            if (wr_en && bus.address == ADDR_FALL_EN)  fall_en  <= wr_bits;
            if (wr_en && bus.address == ADDR_IRQ_MASK) irq_mask <= wr_bits;
            // A new edge is ORed in after the clear so a coincident W1C never loses it.
            if (wr_en && bus.address == ADDR_CAPTURE)
                capture <= (capture & ~wr_bits) | qual;
            else
                capture <= capture | qual;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_count <= '0;
        end else if (wr_en && bus.address == ADDR_EVT_CNT) begin
            evt_count <= (|qual) ? COUNT_W'(1) : '0;
        end else if ((|qual) && evt_count != CNT_MAX) begin
            evt_count <= evt_count + 1'b1;
        end
    end

    // NOTE: the default assignment ahead of the case keeps this mux purely combinational (no latch).
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:     rd_mux[WIDTH-1:0]   = stable;
            ADDR_RISE_EN:  rd_mux[WIDTH-1:0]   = rise_en;
            ADDR_IRQ_MASK: rd_mux[WIDTH-1:0]   = irq_mask;
            ADDR_CAPTURE:  rd_mux[WIDTH-1:0]   = capture;
            ADDR_FALL_EN:  rd_mux[WIDTH-1:0]   = fall_en;
            ADDR_EVT_CNT:  rd_mux[COUNT_W-1:0] = evt_count;
            default:       rd_mux              = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= rd_mux;
    end

endmodule

// File: tb/tb_inp_pio_edge_ctrl.sv
// Directed bench for inp_pio_edge_ctrl; inputs driven and outputs sampled on the falling clock edge.
module tb_inp_pio_edge_ctrl;
    localparam int WIDTH       = 3;
    localparam int SYNC_STAGES = 2;
    localparam int COUNT_W     = 16;
    localparam int DEB_CYCLES  = 4;
`ifdef INP_PIO_DEBOUNCE_EN
    localparam int LAT  = SYNC_STAGES + DEB_CYCLES + 1;
    localparam int HOLD = DEB_CYCLES + 2;
`else
    localparam int LAT  = SYNC_STAGES + 1;
    localparam int HOLD = 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_port;
    logic             irq;
    logic [31:0]      rd;
    int               n_checks = 0;
    int               n_pass   = 0;

    inp_pio_edge_ctrl_if bus ();

    inp_pio_edge_ctrl #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .COUNT_W(COUNT_W), .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        @(negedge clk);
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_port = '0;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        cycles(3);
        reset = 1'b0;
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else n_pass++;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            n_checks++; if (rd !== 32'h0) $display("FAIL reset_reg%0d: got %h expected 0", a, rd); else n_pass++;
        end
    endtask

    task automatic test_rise;
        bus_write(1, 32'hFFFF_FFF8);
        bus_read(1, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL rise_en_upper_bits: got %h expected 0", rd); else n_pass++;
        bus_write(1, 32'h7);
        bus_write(2, 32'h1);
        in_port = 3'b001;
        cycles(LAT - 1);
        n_checks++; if (irq !== 1'b0) $display("FAIL rise_irq_early: got %b expected 0", irq); else n_pass++;
        cycles(1);
        n_checks++; if (irq !== 1'b1) $display("FAIL rise_irq: got %b expected 1", irq); else n_pass++;
        bus_read(0, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL rise_data_high: got %h expected 1", rd); else n_pass++;
        bus_read(3, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL rise_capture: got %h expected 1", rd); else n_pass++;
        cycles(10 - (LAT + 2));
        in_port = 3'b000;
        cycles(LAT + 2);
        bus_read(0, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL rise_data_low: got %h expected 0", rd); else n_pass++;
        bus_read(5, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL rise_count: got %h expected 1", rd); else n_pass++;
        bus_write(3, 32'h7);
        n_checks++; if (irq !== 1'b0) $display("FAIL rise_irq_clear: got %b expected 0", irq); else n_pass++;
        bus_write(5, 32'h0);
    endtask

    task automatic test_fall;
        bus_write(1, 32'h0);
        bus_write(4, 32'h2);
        bus_write(2, 32'h2);
        in_port = 3'b010;
        cycles(LAT + 2);
        bus_read(3, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL fall_no_rise_capture: got %h expected 0", rd); else n_pass++;
        in_port = 3'b000;
        cycles(LAT + 2);
        bus_read(3, rd);
        n_checks++; if (rd !== 32'h2) $display("FAIL fall_capture: got %h expected 2", rd); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL fall_irq: got %b expected 1", irq); else n_pass++;
        bus_write(3, 32'h2);
        n_checks++; if (irq !== 1'b0) $display("FAIL fall_irq_w1c: got %b expected 0", irq); else n_pass++;
        bus_read(3, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL fall_capture_w1c: got %h expected 0", rd); else n_pass++;
        bus_write(5, 32'h0);
    endtask

    task automatic test_w1c_collision;
        bus_write(4, 32'h0);
        bus_write(1, 32'h5);
        bus_write(2, 32'h0);
        in_port = 3'b001;
        cycles(LAT + 2);
        bus_read(3, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL w1c_setup: got %h expected 1", rd); else n_pass++;
        in_port = 3'b101;
        cycles(LAT - 1);
        bus_write(3, 32'h4);
        bus_read(3, rd);
        n_checks++; if (rd !== 32'h5) $display("FAIL w1c_set_wins: got %h expected 5", rd); else n_pass++;
        bus_write(3, 32'h1);
        bus_read(3, rd);
        n_checks++; if (rd !== 32'h4) $display("FAIL w1c_bit0_only: got %h expected 4", rd); else n_pass++;
        bus_write(3, 32'h4);
        bus_read(3, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL w1c_bit2: got %h expected 0", rd); else n_pass++;
        in_port = 3'b000;
        cycles(LAT + 2);
        bus_read(5, rd);
        n_checks++; if (rd !== 32'h2) $display("FAIL w1c_count: got %h expected 2", rd); else n_pass++;
    endtask

    task automatic test_counter;
        bus_write(5, 32'h0);
        bus_write(1, 32'h1);
        bus_write(4, 32'h1);
        bus_write(2, 32'h0);
        repeat (10) begin in_port[0] = ~in_port[0]; cycles(HOLD); end
        cycles(LAT + 1);
        bus_read(5, rd);
        n_checks++; if (rd !== 32'd10) $display("FAIL count_ten: got %h expected a", rd); else n_pass++;
`ifndef INP_PIO_DEBOUNCE_EN
        repeat (65525) begin in_port[0] = ~in_port[0]; cycles(1); end
        cycles(LAT + 1);
        bus_read(5, rd);
        n_checks++; if (rd !== 32'hFFFF) $display("FAIL count_full: got %h expected ffff", rd); else n_pass++;
        in_port[0] = ~in_port[0];
        cycles(LAT + 1);
        bus_read(5, rd);
        n_checks++; if (rd !== 32'hFFFF) $display("FAIL count_saturate: got %h expected ffff", rd); else n_pass++;
`endif
        in_port[0] = ~in_port[0];
        cycles(LAT - 1);
        bus_write(5, 32'h0);
        bus_read(5, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL count_clear_collide: got %h expected 1", rd); else n_pass++;
    endtask

    task automatic test_glitch;
        in_port = 3'b000;
        bus_write(4, 32'h0);
        cycles(LAT + 2);
        bus_write(3, 32'h7);
        bus_write(5, 32'h0);
        bus_write(1, 32'h1);
        bus_write(2, 32'h1);
`ifdef INP_PIO_DEBOUNCE_EN
        in_port = 3'b001;
        cycles(3);
        in_port = 3'b000;
        cycles(LAT + 2);
        bus_read(0, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL glitch_data: got %h expected 0", rd); else n_pass++;
        bus_read(3, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL glitch_capture: got %h expected 0", rd); else n_pass++;
        bus_read(5, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL glitch_count: got %h expected 0", rd); else n_pass++;
        in_port = 3'b001;
        cycles(5);
        in_port = 3'b000;
        cycles(1);
        n_checks++; if (irq !== 1'b0) $display("FAIL deb_irq_early: got %b expected 0", irq); else n_pass++;
        cycles(1);
        n_checks++; if (irq !== 1'b1) $display("FAIL deb_irq: got %b expected 1", irq); else n_pass++;
        cycles(LAT + 2);
        bus_read(0, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL deb_data_after: got %h expected 0", rd); else n_pass++;
`else
        in_port = 3'b001;
        cycles(1);
        in_port = 3'b000;
        cycles(LAT - 2);
        n_checks++; if (irq !== 1'b0) $display("FAIL pulse_irq_early: got %b expected 0", irq); else n_pass++;
        cycles(1);
        n_checks++; if (irq !== 1'b1) $display("FAIL pulse_irq: got %b expected 1", irq); else n_pass++;
        cycles(LAT + 2);
`endif
        bus_read(5, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL pulse_count: got %h expected 1", rd); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bus_write(3, 32'h7);
        bus_write(5, 32'h0);
        bus_write(1, 32'h7);
        bus_write(2, 32'h7);
        in_port = 3'b111;
        cycles(LAT + 2);
        n_checks++; if (irq !== 1'b1) $display("FAIL mid_irq_before: got %b expected 1", irq); else n_pass++;
        bus_read(3, rd);
        n_checks++; if (rd !== 32'h7) $display("FAIL mid_capture_before: got %h expected 7", rd); else n_pass++;
        bus.address = 3'd3;
        reset = 1'b1;
        cycles(1);
        n_checks++; if (irq !== 1'b0) $display("FAIL mid_reset_irq: got %b expected 0", irq); else n_pass++;
        n_checks++; if (bus.readdata !== 32'h0) $display("FAIL mid_reset_readdata: got %h expected 0", bus.readdata); else n_pass++;
        cycles(1);
        reset = 1'b0;
        bus_write(1, 32'h7);
        cycles(LAT + 2);
        bus_read(3, rd);
        n_checks++; if (rd !== 32'h7) $display("FAIL mid_recapture: got %h expected 7", rd); else n_pass++;
        bus_read(2, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL mid_mask_cleared: got %h expected 0", rd); else n_pass++;
        bus_read(4, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL mid_fall_cleared: got %h expected 0", rd); else n_pass++;
        bus_read(5, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL mid_count_one: got %h expected 1", rd); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL mid_irq_masked: got %b expected 0", irq); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_w1c_collision();
        test_counter();
        test_glitch();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
